multicycle_alu: RTL and testbench

//  Parametrised ALU for the multi-cycle datapath, replacing the single-cycle ALU.

---
 rtl/multicycle_alu_if.sv | 52 +++++
 rtl/multicycle_alu.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// ----------------------------------------------------------------------------
// multicycle_alu_if
// Bundles the request/response signals between the datapath controller
// (master) and the multi-cycle ALU (slave).
//
// Signals
//   start      master->slave  request, taken only while ready=1
//   op         master->slave  3-bit operation code
//   ovf_en     master->slave  enable signed add/sub overflow flag
//   a, b       master->slave  operands, sampled on the accepting edge only
//   ready      slave->master  ALU idle, a start on this edge is accepted
//   busy       slave->master  inverse of ready
//   done       slave->master  one-cycle pulse, results valid
//   result_lo  slave->master  result / product low / quotient
//   result_hi  slave->master  0 / product high / remainder
//   zero       slave->master  result_lo == 0
//   overflow   slave->master  signed add/sub overflow
//   div_zero   slave->master  divide by zero
//
// Handshake: a request is accepted on a rising clock edge where
// start=1 and ready=1. Operands and op are captured on that edge only.
// start while ready=0 is dropped, not queued. Completion is signalled by
// a single-cycle done pulse; ready is already 1 in that cycle so a new
// request may be accepted back-to-back.
// ----------------------------------------------------------------------------
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             ovf_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             div_zero;

    modport master (
        output start, op, ovf_en, a, b,
        input  ready, busy, done, result_lo, result_hi, zero, overflow, div_zero
    );

    modport slave (
        input  start, op, ovf_en, a, b,
        output ready, busy, done, result_lo, result_hi, zero, overflow, div_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// ----------------------------------------------------------------------------
// multicycle_alu
// ALU for the multi-cycle datapath. ADD/SUB/OR/AND/SLT complete on the
// accepting edge. Signed MUL and signed/unsigned DIV iterate one bit per
// clock for WIDTH clocks, followed by one sign-fixup clock, giving a
// latency of WIDTH+1 from the accepting edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          multicycle_alu_if slave modport (request/response)
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC)
// ----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_alu_if.slave        bus,
    output logic                   o_dbg_state
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_DIVU = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    localparam int              CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_W  = CW'(WIDTH);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    // MUL: r_hi = partial product, r_lo = multiplier shifting out.
    // DIV: r_hi = partial remainder, r_lo = dividend shifting out /
    //      quotient shifting in.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_a_orig;   // raw dividend, returned on divide by zero
    logic             r_neg_q;    // negate product / quotient at the end
    logic             r_neg_r;    // negate remainder at the end

    logic             r_done;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dz;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_accept;
    logic w_iter;
    logic w_signed_op;

    assign w_ready     = (r_state == ST_IDLE);
    assign w_accept    = bus.start & w_ready;
    assign w_iter      = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign w_signed_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub_ab;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_sc_lo;
    logic             w_sc_ovf;

    assign w_add     = bus.a + bus.b;
    assign w_sub_ab  = bus.a - bus.b;
    assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub_ab[WIDTH-1] != bus.a[WIDTH-1]);
    // Direct signed compare, so a wrapped a-b cannot corrupt the answer.
    assign w_slt     = ($signed(bus.a) < $signed(bus.b));

    always_comb begin
        w_sc_lo  = '0;
        w_sc_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_sc_lo  = w_add;
                w_sc_ovf = bus.ovf_en & w_add_ovf;
            end
            OP_SUB: begin
                w_sc_lo  = w_sub_ab;
                w_sc_ovf = bus.ovf_en & w_sub_ovf;
            end
            OP_OR:   w_sc_lo = bus.a | bus.b;
            OP_AND:  w_sc_lo = bus.a & bus.b;
            OP_SLT:  w_sc_lo = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_sc_lo = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand magnitudes for the iterative ops (DIVU keeps raw bits)
    // ------------------------------------------------------------------
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_a_neg = w_signed_op & bus.a[WIDTH-1];
    assign w_b_neg = w_signed_op & bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    // Restoring division: shift the next dividend bit into the remainder.
    // The partial remainder stays below the divisor, so when a subtract
    // happens its result always fits in WIDTH bits.
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opnd});
    assign w_sub     = w_shift[WIDTH-1:0] - r_opnd;

    // ------------------------------------------------------------------
    // Final sign fix-up for the iterative ops
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fin_lo;
    logic [WIDTH-1:0]   w_fin_hi;
    logic               w_fin_dz;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;

    always_comb begin
        w_fin_lo = '0;
        w_fin_hi = '0;
        w_fin_dz = 1'b0;
        if (r_op == OP_MUL) begin
            w_fin_lo = w_prod_fix[WIDTH-1:0];
            w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end else if (r_opnd == '0) begin
            w_fin_lo = '1;
            w_fin_hi = r_a_orig;
            w_fin_dz = 1'b1;
        end else begin
            w_fin_lo = r_neg_q ? (~r_lo + 1'b1) : r_lo;
            w_fin_hi = r_neg_r ? (~r_hi + 1'b1) : r_hi;
        end
    end

    // ------------------------------------------------------------------
    // FSM and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_ADD;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_a_orig <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_op     <= bus.op;
                            r_cnt    <= '0;
                            r_hi     <= '0;
                            r_a_orig <= bus.a;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            if (bus.op == OP_MUL) begin
                                r_lo   <= w_b_mag;
                                r_opnd <= w_a_mag;
                            end else begin
                                r_lo   <= w_a_mag;
                                r_opnd <= w_b_mag;
                            end
                            r_state <= ST_CALC;
                        end else begin
                            r_res_lo <= w_sc_lo;
                            r_res_hi <= '0;
                            r_zero   <= (w_sc_lo == '0);
                            r_ovf    <= w_sc_ovf;
                            r_dz     <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (r_cnt != CNT_W) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op == OP_MUL) begin
                            r_hi <= w_mul_sum[WIDTH:1];
                            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        end else if (w_ge) begin
                            r_hi <= w_sub;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_shift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_res_lo <= w_fin_lo;
                        r_res_hi <= w_fin_hi;
                        r_zero   <= (w_fin_lo == '0);
                        r_ovf    <= 1'b0;
                        r_dz     <= w_fin_dz;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready     = w_ready;
    assign bus.busy      = ~w_ready;
    assign bus.done      = r_done;
    assign bus.result_lo = r_res_lo;
    assign bus.result_hi = r_res_hi;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.div_zero  = r_dz;
    assign o_dbg_state   = r_state[0];

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_DIVU = 3'd7;

  // clock / reset
  logic clk;
  logic rst_n;
  logic dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int total;
  int bad;

  // driver: present one request at the falling edge, hold through the
  // accepting rising edge, then scramble the operand inputs
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ovf);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a      = a;
    bus.b      = b;
    bus.ovf_en = ovf;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.op     = 3'($urandom_range(0, 7));
  endtask

  // bounded wait for done; cyc = rising edges after the accepting edge
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = OP_ADD;
    bus.a      = '0;
    bus.b      = '0;
    bus.ovf_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.done, bus.result_lo, bus.result_hi, bus.zero, bus.overflow, bus.div_zero} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got done=%b lo=%h hi=%h z=%b o=%b dz=%b want all 0",
               bus.done, bus.result_lo, bus.result_hi, bus.zero, bus.overflow, bus.div_zero);
    end
    total++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got ready=%b busy=%b st=%b want 1 0 0", bus.ready, bus.busy, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_ovf();
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    total++;
    if (bus.done !== 1'b1 || bus.result_lo !== 32'h8000_0000 || bus.result_hi !== 32'h0 ||
        bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL add_ovf: got done=%b lo=%h hi=%h o=%b z=%b want 1 80000000 0 1 0",
               bus.done, bus.result_lo, bus.result_hi, bus.overflow, bus.zero);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.result_lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL done_pulse_hold: got done=%b lo=%h want 0 80000000", bus.done, bus.result_lo);
    end
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    total++;
    if (bus.overflow !== 1'b0 || bus.result_lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL add_no_ovf_en: got o=%b lo=%h want 0 80000000", bus.overflow, bus.result_lo);
    end
    issue(OP_SUB, 32'h8000_0000, 32'h1, 1'b1);
    total++;
    if (bus.overflow !== 1'b1 || bus.result_lo !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL sub_ovf: got o=%b lo=%h want 1 7fffffff", bus.overflow, bus.result_lo);
    end
  endtask

  task automatic test_logic_slt();
    issue(OP_SLT, 32'h8000_0000, 32'h1, 1'b1);
    total++;
    if (bus.result_lo !== 32'h1 || bus.overflow !== 1'b0 || bus.result_hi !== 32'h0) begin
      bad++;
      $display("FAIL slt_neg: got lo=%h o=%b hi=%h want 1 0 0", bus.result_lo, bus.overflow, bus.result_hi);
    end
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    total++;
    if (bus.result_lo !== 32'h0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL slt_pos: got lo=%h z=%b want 0 1", bus.result_lo, bus.zero);
    end
    issue(OP_SUB, 32'd5, 32'd5, 1'b1);
    total++;
    if (bus.result_lo !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL sub_zero: got lo=%h z=%b o=%b want 0 1 0", bus.result_lo, bus.zero, bus.overflow);
    end
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0);
    total++;
    if (bus.result_lo !== 32'hF0F0_0F0F) begin
      bad++;
      $display("FAIL or: got lo=%h want f0f00f0f", bus.result_lo);
    end
    issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    total++;
    if (bus.result_lo !== 32'h0F00_0F00) begin
      bad++;
      $display("FAIL and: got lo=%h want 0f000f00", bus.result_lo);
    end
  endtask

  task automatic test_div();
    int cyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    total++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || dbg_state !== 1'b1) begin
      bad++;
      $display("FAIL div_busy: got busy=%b ready=%b st=%b want 1 0 1", bus.busy, bus.ready, dbg_state);
    end
    wait_done(cyc);
    total++;
    if (cyc != 33) begin
      bad++;
      $display("FAIL div_latency: got %0d cycles want 33", cyc);
    end
    total++;
    if (bus.result_lo !== 32'hFFFF_FFFD || bus.result_hi !== 32'hFFFF_FFFF || bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_signed: got lo=%h hi=%h dz=%b want fffffffd ffffffff 0",
               bus.result_lo, bus.result_hi, bus.div_zero);
    end
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.result_lo !== 32'h7FFF_FFFC || bus.result_hi !== 32'h1) begin
      bad++;
      $display("FAIL divu: got cyc=%0d lo=%h hi=%h want 33 7ffffffc 1", cyc, bus.result_lo, bus.result_hi);
    end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc);
    total++;
    if (bus.result_lo !== 32'h8000_0000 || bus.result_hi !== 32'h0 ||
        bus.overflow !== 1'b0 || bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_min_m1: got lo=%h hi=%h o=%b dz=%b want 80000000 0 0 0",
               bus.result_lo, bus.result_hi, bus.overflow, bus.div_zero);
    end
    issue(OP_DIV, 32'd9, 32'd0, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.result_lo !== 32'hFFFF_FFFF || bus.result_hi !== 32'd9 ||
        bus.div_zero !== 1'b1 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL div_by_zero: got cyc=%0d lo=%h hi=%h dz=%b z=%b want 33 ffffffff 9 1 0",
               cyc, bus.result_lo, bus.result_hi, bus.div_zero, bus.zero);
    end
    issue(OP_OR, 32'h0, 32'h0, 1'b0);
    total++;
    if (bus.div_zero !== 1'b0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_cleared: got dz=%b z=%b want 0 1", bus.div_zero, bus.zero);
    end
  endtask

  task automatic test_mul();
    int cyc;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 33 || bus.result_hi !== 32'hFFFF_FFFF || bus.result_lo !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL mul_neg: got cyc=%0d hi=%h lo=%h want 33 ffffffff fffffffe", cyc, bus.result_hi, bus.result_lo);
    end
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(cyc);
    total++;
    if (bus.result_hi !== 32'h4000_0000 || bus.result_lo !== 32'h0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL mul_min_min: got hi=%h lo=%h z=%b want 40000000 0 1", bus.result_hi, bus.result_lo, bus.zero);
    end
    issue(OP_MUL, 32'd12345, 32'd6789, 1'b0);
    wait_done(cyc);
    total++;
    if (bus.result_hi !== 32'h0 || bus.result_lo !== 32'd83810205) begin
      bad++;
      $display("FAIL mul_pos: got hi=%h lo=%h want 0 %h", bus.result_hi, bus.result_lo, 32'd83810205);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(OP_MUL, 32'd3, 32'hFFFF_FFFC, 1'b0);
    wait_done(cyc);
    total++;
    if (bus.ready !== 1'b1 || bus.result_lo !== 32'hFFFF_FFF4 || bus.result_hi !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL b2b_mul: got ready=%b lo=%h hi=%h want 1 fffffff4 ffffffff",
               bus.ready, bus.result_lo, bus.result_hi);
    end
    // still in the completion cycle: this request lands on the next edge
    issue(OP_ADD, 32'd100, 32'd23, 1'b0);
    total++;
    if (bus.done !== 1'b1 || bus.result_lo !== 32'd123 || bus.result_hi !== 32'h0) begin
      bad++;
      $display("FAIL b2b_add: got done=%b lo=%h hi=%h want 1 7b 0", bus.done, bus.result_lo, bus.result_hi);
    end
  endtask

  task automatic test_ignore_and_reset();
    int ign_bad;
    issue(OP_MUL, 32'd3, 32'd4, 1'b0);
    ign_bad = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.result_lo !== 32'd123) ign_bad++;
    end
    bus.start = 1'b0;
    total++;
    if (ign_bad != 0) begin
      bad++;
      $display("FAIL start_while_busy: got %0d bad cycles want 0 (done=%b busy=%b lo=%h)",
               ign_bad, bus.done, bus.busy, bus.result_lo);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.done, bus.result_lo, bus.result_hi, bus.zero, bus.overflow, bus.div_zero} !== '0 ||
        bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_reset: got done=%b lo=%h hi=%h ready=%b want 0 0 0 1",
               bus.done, bus.result_lo, bus.result_hi, bus.ready);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done=%b want 0", bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 32'd2, 32'd3, 1'b0);
    total++;
    if (bus.done !== 1'b1 || bus.result_lo !== 32'd5) begin
      bad++;
      $display("FAIL post_reset_add: got done=%b lo=%h want 1 5", bus.done, bus.result_lo);
    end
    // let any leftover multiply (if reset failed to abort) show itself
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL stray_done: got done=%b lo=%h want no done", bus.done, bus.result_lo);
        break;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_ovf();
    test_logic_slt();
    test_div();
    test_mul();
    test_back_to_back();
    test_ignore_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
